// File: rtl/pcs_pkg.sv
// pcs_pkg: lane count, skew limits and state type for the PCS receive deskew control
package pcs_pkg;
  localparam int LANE_N = 4;
  localparam int BLOCK_W = 66;
  localparam int MAX_SKEW_BIT_N = 1856;
  localparam int MAX_SKEW_BLK_N = (MAX_SKEW_BIT_N - BLOCK_W - 1) / BLOCK_W;
  localparam int DELAY_W = $clog2(MAX_SKEW_BLK_N + 1);
  typedef enum logic [1:0] {WAIT_LOCK, MEASURE, ALIGNED} deskew_state_t;
endpackage

// File: rtl/deskew_arrival.sv
// deskew_arrival: per-lane marker arrival capture with duplicate detect
module deskew_arrival
  import pcs_pkg::*;
(
  input  logic               clk,
  input  logic               nreset,
  input  logic               clear_i,
  input  logic               mk_i,
  input  logic [DELAY_W-1:0] cnt_i,
  output logic               seen_o,
  output logic [DELAY_W-1:0] arr_o,
  output logic               dup_o
);
  logic               seen_q;
  logic [DELAY_W-1:0] arr_q;
  // seen/arr include this cycle's marker so a window can close on its last marker
  assign seen_o = seen_q | mk_i;
  assign arr_o = mk_i ? cnt_i : arr_q;
  assign dup_o = seen_q & mk_i;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      seen_q <= 1'b0;
      arr_q <= '0;
    end else begin
      seen_q <= clear_i ? 1'b0 : seen_o;
      arr_q <= clear_i ? '0 : arr_o;
    end
endmodule

// File: rtl/deskew_ctrl_rx.sv
// deskew_ctrl_rx: lock/measure/aligned control for the PCS receive deskew buffer
module deskew_ctrl_rx
  import pcs_pkg::*;
(
  input  logic                      clk,
  input  logic                      nreset,
  input  logic [LANE_N-1:0]         valid_i,
  input  logic [LANE_N-1:0]         am_lock_v_i,
  input  logic [LANE_N-1:0]         am_v_i,
  output logic [LANE_N*DELAY_W-1:0] delay_o,
  output logic                      delay_v_o,
  output logic                      align_status_o,
  output logic                      deskew_err_o
);
  deskew_state_t state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d, arr_max;
  logic open_q, open_d, err_q;
  logic [LANE_N*DELAY_W-1:0] delay_q, delay_d, ref_q, arr;
  logic [LANE_N-1:0] mk, seen, dup;
  logic lock, active, open_now, tout, done, err, clear, store;
  assign lock = &am_lock_v_i;
  assign active = lock && state_q != WAIT_LOCK;
  assign mk = am_v_i & valid_i & {LANE_N{active}};
  assign open_now = open_q | (|mk);
  assign tout = cnt_q > DELAY_W'(MAX_SKEW_BLK_N);
  assign done = active && open_now && (&seen) && !(|dup) && !tout;
  assign err = active && ((|dup) || tout || (done && state_q == ALIGNED && arr != ref_q));
  assign clear = !active || err || done;
  assign store = done && state_q == MEASURE;
  assign cnt_d = clear ? '0 : cnt_q + DELAY_W'(open_now & (&valid_i));
  assign open_d = !clear && open_now;
  for (genvar i = 0; i < LANE_N; i++) begin : g_lane
    deskew_arrival u_arr (
      .clk(clk),
      .nreset(nreset),
      .clear_i(clear),
      .mk_i(mk[i]),
      .cnt_i(cnt_q),
      .seen_o(seen[i]),
      .arr_o(arr[i*DELAY_W +: DELAY_W]),
      .dup_o(dup[i])
    );
  end
  always_comb begin
    arr_max = '0;
    for (int k = 0; k < LANE_N; k++)
      arr_max = arr[k*DELAY_W +: DELAY_W] > arr_max ? arr[k*DELAY_W +: DELAY_W] : arr_max;
    delay_d = '0;
    for (int k = 0; k < LANE_N; k++)
      delay_d[k*DELAY_W +: DELAY_W] = arr_max - arr[k*DELAY_W +: DELAY_W];
  end
  // lock loss outranks both errors and a completing window
  always_comb
    state_d = !lock ? WAIT_LOCK
            : (state_q == WAIT_LOCK || err) ? MEASURE
            : done ? ALIGNED : state_q;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state_q <= WAIT_LOCK;
      cnt_q <= '0;
      open_q <= 1'b0;
      delay_q <= '0;
      ref_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      open_q <= open_d;
      err_q <= err;
      if (store) begin
        delay_q <= delay_d;
        ref_q <= arr;
      end
    end
  assign delay_o = delay_q;
  assign delay_v_o = state_q == ALIGNED;
  assign align_status_o = state_q == ALIGNED;
  assign deskew_err_o = err_q;
endmodule
